// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode constants, command layout,
// result width and control FSM encoding.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int OPND_W = 2;
    localparam int CMD_W  = OP_W + OPND_W;
    localparam int RES_W  = 5;

    localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0010;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0011;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0100;
    localparam logic [OP_W-1:0] OP_MUL   = 4'b0101;
    localparam logic [OP_W-1:0] OP_DIV   = 4'b0110;
    localparam logic [OP_W-1:0] OP_MOD   = 4'b0111;
    localparam logic [OP_W-1:0] OP_NANDB = 4'b1111;

    // opnd[0] is operand A, opnd[1] is operand B
    typedef struct packed {
        logic [OP_W-1:0]   st;
        logic [OPND_W-1:0] opnd;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage; power-of-two depth, pointers wrap
// naturally and the occupancy counter distinguishes full from empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     din,
    output cmd_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage between a command stream and an external combinational ALU.
// Optional macro ALU_ISSUE_DIVZERO_EN adds res_err and zeroes div/mod by zero.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_st,
    input  logic [OPND_W-1:0] cmd_in,
    output logic [OP_W-1:0]   alu_st,
    output logic [OPND_W-1:0] alu_in,
    input  logic [RES_W-1:0]  alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
`ifdef ALU_ISSUE_DIVZERO_EN
    output logic [OP_W-1:0]   res_op,
    output logic              res_err
`else
    output logic [OP_W-1:0]   res_op
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_push;
    logic              w_issue;
    logic              w_valid_nxt;
    logic [RES_W-1:0]  w_res;
    logic              w_err;

    logic              r_res_valid;
    logic [RES_W-1:0]  r_res_data;
    logic [OP_W-1:0]   r_res_op;
    logic              r_res_err;
    state_t            r_state;

    assign cmd_ready   = !w_full;
    assign w_push      = cmd_valid && !w_full;
    assign w_issue     = !w_empty && (!r_res_valid || res_ready);
    assign w_valid_nxt = w_issue || (r_res_valid && !res_ready);
    assign w_cnt_nxt   = w_count + CW'(w_push) - CW'(w_issue);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_issue),
        .din   ({cmd_st, cmd_in}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign alu_st = w_empty ? '0 : w_head.st;
    assign alu_in = w_empty ? '0 : w_head.opnd;

    always_comb begin
        w_res = alu_out;
        w_err = 1'b0;
`ifdef ALU_ISSUE_DIVZERO_EN
        if ((w_head.st == OP_DIV || w_head.st == OP_MOD) && !w_head.opnd[1]) begin
            w_res = '0;
            w_err = 1'b1;
        end
`endif
    end

    // Result register: reload on issue, otherwise drain on res_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
            r_res_err   <= 1'b0;
        end else if (w_issue) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_res;
            r_res_op    <= w_head.st;
            r_res_err   <= w_err;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_push) r_state <= ST_RUN;
                ST_RUN: begin
                    if (r_res_valid && !res_ready && !w_empty)
                        r_state <= ST_STALL;
                    else if (w_cnt_nxt == '0 && !w_valid_nxt)
                        r_state <= ST_IDLE;
                end
                ST_STALL: if (res_ready) r_state <= ST_RUN;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;
`ifdef ALU_ISSUE_DIVZERO_EN
    assign res_err   = r_res_err;
`else
    logic w_unused_err;
    assign w_unused_err = r_res_err ^ w_err ^ (r_state == ST_STALL);
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised bench for alu_issue_stage: a queue-based reference model of the
// issue stage plus a behavioural ALU; define ALU_ISSUE_DIVZERO_EN for res_err.
module tb_alu_issue_stage;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_st;
    logic [1:0] cmd_in;
    logic [3:0] alu_st;
    logic [1:0] alu_in;
    logic [4:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic [3:0] res_op;
`ifdef ALU_ISSUE_DIVZERO_EN
    logic       res_err;
`endif

    int n_tot = 0;
    int n_bad = 0;

    logic [5:0] q[$];
    logic       m_vld;
    logic [4:0] m_data;
    logic [3:0] m_op;
    logic       m_err;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_st    (cmd_st),
        .cmd_in    (cmd_in),
        .alu_st    (alu_st),
        .alu_in    (alu_in),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
`ifdef ALU_ISSUE_DIVZERO_EN
        .res_op    (res_op),
        .res_err   (res_err)
`else
        .res_op    (res_op)
`endif
    );

    // Behavioural external ALU: A = in[0], B = in[1]
    function automatic logic [4:0] alu_ref(input logic [3:0] op, input logic [1:0] in);
        int a, b, r;
        a = int'(in[0]);
        b = int'(in[1]);
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a ^ b;
            4'd3:  r = a + b;
            4'd4:  r = a - b;
            4'd5:  r = a * b;
            4'd6:  r = (b != 0) ? a / b : 31;
            4'd7:  r = (b != 0) ? a % b : 30;
            4'd8:  r = (a & b) ^ 1;
            4'd9:  r = (a | b) ^ 1;
            4'd10: r = (a ^ b) ^ 1;
            4'd11: r = a;
            4'd12: r = b;
            4'd13: r = a + b + 1;
            4'd14: r = 16 + a;
            default: r = (a ^ 1) + b;
        endcase
        return r[4:0];
    endfunction

    always_comb alu_out = alu_ref(alu_st, alu_in);

    function automatic logic is_divzero(input logic [5:0] c);
`ifdef ALU_ISSUE_DIVZERO_EN
        return (c[5:2] == 4'd6 || c[5:2] == 4'd7) && !c[1];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle-level reference: a queue of pending commands and one output slot
    task automatic model_edge();
        logic       room;
        logic [5:0] c;
        if (rst) begin
            q.delete();
            m_vld  = 1'b0;
            m_data = '0;
            m_op   = '0;
            m_err  = 1'b0;
        end else begin
            room = q.size() < DEPTH;
            if (q.size() > 0 && (!m_vld || res_ready)) begin
                c      = q.pop_front();
                m_vld  = 1'b1;
                m_op   = c[5:2];
                m_err  = is_divzero(c);
                m_data = m_err ? 5'd0 : alu_ref(c[5:2], c[1:0]);
            end else if (res_ready) begin
                m_vld = 1'b0;
            end
            if (cmd_valid && room) q.push_back({cmd_st, cmd_in});
        end
    endtask

    task automatic check_all();
        logic [5:0] h;
        h = (q.size() > 0) ? q[0] : 6'd0;
        chk("ready", cmd_ready, q.size() < DEPTH);
        chk("valid", res_valid, m_vld);
        chk("alu_st", alu_st, h[5:2]);
        chk("alu_in", alu_in, h[1:0]);
        if (m_vld) begin
            chk("data", res_data, m_data);
            chk("op", res_op, m_op);
`ifdef ALU_ISSUE_DIVZERO_EN
            chk("err", res_err, m_err);
`endif
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_cmd();
        cmd_st = 4'($urandom_range(0, 15));
        cmd_in = 2'($urandom_range(0, 3));
    endtask

    initial begin
        logic [4:0] b2b_exp [3];
        b2b_exp = '{5'd1, 5'd1, 5'd0};
        rst = 1'b1; cmd_valid = 1'b0; cmd_st = '0; cmd_in = '0; res_ready = 1'b0;
        m_vld = 1'b0; m_data = '0; m_op = '0; m_err = 1'b0;

        cyc(); cyc();
        rst = 1'b0;
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_data", res_data, 5'd0);
        chk("rst_op", res_op, 4'd0);
        chk("rst_alu_st", alu_st, 4'd0);

        // Single op, minimum latency
        res_ready = 1'b1; cmd_valid = 1'b1; cmd_st = 4'b0011; cmd_in = 2'b11;
        cyc();
        chk("lat_e1_valid", res_valid, 1'b0);
        cmd_valid = 1'b0;
        cyc();
        chk("lat_e2_valid", res_valid, 1'b1);
        chk("lat_e2_data", res_data, 5'b00010);
        chk("lat_e2_op", res_op, 4'b0011);
        cyc();

        // Back-to-back, one result per cycle
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_st = 4'(i); cmd_in = 2'b11;
            cyc();
            if (i >= 1) begin
                chk("b2b_data", res_data, b2b_exp[i-1]);
                chk("b2b_op", res_op, 4'(i-1));
            end
        end
        cmd_valid = 1'b0;
        cyc();
        chk("b2b_last_data", res_data, b2b_exp[2]);
        chk("b2b_last_op", res_op, 4'd2);
        cyc(); cyc();

        // Fill: one result held, DEPTH queued, further pushes refused
        res_ready = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_cmd();
            cyc();
        end
        chk("fill_ready", cmd_ready, 1'b0);
        chk("fill_valid", res_valid, 1'b1);
        rand_cmd();
        for (int i = 0; i < 3; i++) cyc();
        chk("fill_hold_ready", cmd_ready, 1'b0);

        // Random traffic with toggling backpressure
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            rand_cmd();
            res_ready = (i < 700) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Reset with a pending result and queued commands
        res_ready = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_cmd();
            cyc();
        end
        chk("pre_rst_valid", res_valid, 1'b1);
        rst = 1'b1; res_ready = 1'b1; rand_cmd();
        cyc();
        rst = 1'b0; cmd_valid = 1'b0;
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_alu_st", alu_st, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_valid", res_valid, 1'b0);
        end

`ifdef ALU_ISSUE_DIVZERO_EN
        res_ready = 1'b1; cmd_valid = 1'b1; cmd_st = 4'b0110; cmd_in = 2'b01;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        chk("dz_data", res_data, 5'd0);
        chk("dz_err", res_err, 1'b1);
        cmd_valid = 1'b1; cmd_st = 4'b0110; cmd_in = 2'b11;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        chk("div_data", res_data, 5'd1);
        chk("div_err", res_err, 1'b0);
`endif

        cmd_valid = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("drain_valid", res_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
